slot_display: RTL and testbench
===============================

# slot_display

Output-side driver for the slot machine: consumes the three reel digits and the 32-bit score from the slot FSM and drives an 8-digit, time-multiplexed, common-anode 7-segment display. Reel digits are shown directly. The score is saturated to 9999 and converted to BCD by an iterative converter. All display outputs are registered.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; must be ≥ 2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `resultMSB` input 4: left reel digit, 0–9; values 10–15 display as `-`.
- `result2` input 4: middle reel digit; same encoding.
- `resultLSB` input 4: right reel digit; same encoding.
- `score` input 32: unsigned running score.
- `an` output 8: digit enables, active-low; bit 0 is the rightmost digit.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.

## Operation
- Digit map:
  - digit 7 = `resultMSB`, digit 6 = `result2`, digit 5 = `resultLSB`.
  - digit 4 = blank.
  - digits 3..0 = score thousands..units.
- Score path FSM, states IDLE, CONV, COMMIT:
  - IDLE: when `score` ≠ `last_score`, capture `snap` = min(`score`, 9999) as 14 bits, set `last_score` = `score` and `ovf` = (`score` > 9999), then go to CONV.
  - CONV: 14 double-dabble iterations, one per cycle. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - COMMIT: copy the working BCD into the display register `bcd_q`, copy `ovf` into `ovf_q`, then return to IDLE.
- `bcd_q` changes only in COMMIT, so a half-converted value is never displayed.
- Score leading-zero blanking: digits 3..1 are blank while they and every digit to their left are zero. Digit 0 always shows a value.
- `dp` is low only while digit 0 is enabled and `ovf_q` = 1; otherwise high.
- Segment codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, `-`=3F, blank=7F.
- Refresh:
  - `div_cnt` counts 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and `dig_idx` (3 bits) increments, wrapping 7→0.
  - `an` is the one-cold decode of `dig_idx`.
- Boundary conditions:
  - `score` changes during CONV: the conversion in progress completes with the old snapshot. The new value is captured on the first IDLE cycle after COMMIT.
  - `score` = 9999 or 10000: both display 9999; `dp` is lit only for 10000.
  - `score` = 0xFFFFFFFF: displays 9999 with `dp` lit.
  - `reset` during CONV: the conversion is aborted and nothing is committed.

## Timing
- Reset values (on the edge where `reset` = 1):
  - `an`=FF, `seg`=7F, `dp`=1.
  - `div_cnt`=0, `dig_idx`=0.
  - state IDLE, `last_score`=0, `bcd_q`=0000, `ovf_q`=0.
- After `reset` falls, the first edge drives `an`=FE with the digit-0 code 40 (`0`).
- Score latency:
  - `score` changes before edge N; IDLE captures it at edge N.
  - CONV runs edges N+1..N+14; COMMIT at edge N+15.
  - `bcd_q` is valid after edge N+15.
  - The segment outputs reflect it at edge N+16 or at that digit's next refresh slot, whichever is later.
- Reel digits are not latched internally. The value sampled on the edge that registers `seg` is the one shown, so latency is 1 cycle.
- `an`, `seg` and `dp` update together on the same edge and never glitch between edges.
- Each digit stays enabled for exactly REFRESH_DIV cycles; the full frame is 8×REFRESH_DIV cycles.

## Structure
- Package `slot_pkg` holds:
  - `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`;
  - `SCORE_MAX` = 9999;
  - digit-position constants `DIG_REEL_MSB` = 7, `DIG_REEL_2` = 6, `DIG_REEL_LSB` = 5, `DIG_GAP` = 4;
  - the conversion-state enum.
- Sub-module `slot_bin2bcd`: the iterative 14-bit to 4-digit converter.
  - Ports: `clk`, `reset`, `start`, `bin[13:0]`, `busy`, `done` (1-cycle pulse), `bcd[15:0]`.
  - The top level owns the refresh counter, the digit mux, blanking and segment decode.

## Test plan
- Reset check: assert `reset` for 3 cycles with REFRESH_DIV=4, then release.
  - Expect `an`=FF, `seg`=7F, `dp`=1 during reset.
  - Then `an`=FE with `seg`=40 for 4 cycles, followed by `an`=FD with `seg`=7F (blank leading zero).
- Reel decode: drive `resultMSB`=7, `result2`=7, `resultLSB`=12.
  - Expect `seg`=78 while `an`=7F, `seg`=78 while `an`=BF, `seg`=3F while `an`=DF.
- Score latency: step `score` 0→305.
  - `bcd_q`=0305 exactly 16 cycles after the change.
  - Digits 3..0 show blank, 30, 40, 12; `dp`=1 on all digits.
- Saturation: set `score`=123456.
  - Digits 3..0 show 10 10 10 10 (9999).
  - `dp`=0 only while `an`=FE.
- Mid-conversion update: set `score`=42, then `score`=1000 five cycles later.
  - `bcd_q` reads 0042 at the first COMMIT and 1000 at the next COMMIT, 16 cycles after COMMIT.
- Reset during CONV: assert `reset` 5 cycles into a conversion of 9876.
  - After release, `bcd_q`=0000 and the state is IDLE.
  - With `score` still 9876, a fresh conversion starts on the first cycle after release.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared constants, conversion-state encoding and helper functions for the
// slot machine display path.
package slot_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  localparam logic [2:0] DIG_REEL_MSB = 3'd7;
  localparam logic [2:0] DIG_REEL_2   = 3'd6;
  localparam logic [2:0] DIG_REEL_LSB = 3'd5;
  localparam logic [2:0] DIG_GAP      = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Digits 10..15 have no numeral and render as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_bin2bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter (double dabble, one
// iteration per clock).
module slot_bin2bcd
  import slot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [13:0] bin_r;
  logic [15:0] bcd_r;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] adj_s;

  assign adj_s = dd_adjust(bcd_r);

  // Load on start, then adjust-and-shift once per cycle; done flags the cycle
  // whose closing edge performs the final shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_r  <= 14'd0;
      bcd_r  <= 16'd0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      bin_r  <= bin;
      bcd_r  <= 16'd0;
      cnt_r  <= 4'd14;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (cnt_r != 4'd0) begin
      bcd_r  <= {adj_s[14:0], bin_r[13]};
      bin_r  <= {bin_r[12:0], 1'b0};
      cnt_r  <= cnt_r - 4'd1;
      busy_r <= (cnt_r != 4'd1);
      done_r <= (cnt_r == 4'd2);
    end else begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/slot_display.sv
// Time-multiplexed 8-digit common-anode display driver: three reel digits,
// a gap, and a saturated 4-digit BCD score with leading-zero blanking.
module slot_display
  import slot_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  resultMSB,
  input  logic [3:0]  result2,
  input  logic [3:0]  resultLSB,
  input  logic [31:0] score,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  conv_state_t state_r, next_s;
  logic [31:0] last_score_r;
  logic        ovf_r, ovf_q_r, ovf_s;
  logic [15:0] bcd_q_r;
  logic [13:0] snap_s;
  logic        start_s;
  logic        conv_busy_s, conv_done_s;
  logic [15:0] conv_bcd_s;
  logic [CW-1:0] div_cnt_r;
  logic [2:0]  dig_idx_r;
  logic [6:0]  seg_s;
  logic [7:0]  an_s;
  logic        dp_s;

  assign ovf_s  = (score > {18'd0, SCORE_MAX});
  assign snap_s = ovf_s ? SCORE_MAX : score[13:0];

  slot_bin2bcd u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .bin   (snap_s),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  // Conversion state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; a new score is only sampled from IDLE.
  always_comb begin
    next_s  = state_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if ((score != last_score_r) && !conv_busy_s) begin
          next_s  = CONV;
          start_s = 1'b1;
        end else begin
          next_s  = IDLE;
        end
      end
      CONV: begin
        if (conv_done_s) begin
          next_s = COMMIT;
        end else begin
          next_s = CONV;
        end
      end
      COMMIT:  next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Score snapshot bookkeeping and the display-side BCD register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_score_r <= 32'd0;
      ovf_r        <= 1'b0;
      bcd_q_r      <= 16'd0;
      ovf_q_r      <= 1'b0;
    end else begin
      if (start_s) begin
        last_score_r <= score;
        ovf_r        <= ovf_s;
      end
      if (state_r == COMMIT) begin
        bcd_q_r <= conv_bcd_s;
        ovf_q_r <= ovf_r;
      end
    end
  end

  // Refresh divider and digit scan index.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= '0;
      dig_idx_r <= 3'd0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
      dig_idx_r <= dig_idx_r + 3'd1;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

  // Digit mux with leading-zero blanking of score digits 3..1.
  always_comb begin
    seg_s = SEG_BLANK;
    case (dig_idx_r)
      DIG_REEL_MSB: seg_s = seg_decode(resultMSB);
      DIG_REEL_2:   seg_s = seg_decode(result2);
      DIG_REEL_LSB: seg_s = seg_decode(resultLSB);
      DIG_GAP:      seg_s = SEG_BLANK;
      3'd3: seg_s = (bcd_q_r[15:12] == 4'd0) ? SEG_BLANK : seg_decode(bcd_q_r[15:12]);
      3'd2: seg_s = (bcd_q_r[15:8] == 8'd0) ? SEG_BLANK : seg_decode(bcd_q_r[11:8]);
      3'd1: seg_s = (bcd_q_r[15:4] == 12'd0) ? SEG_BLANK : seg_decode(bcd_q_r[7:4]);
      3'd0: seg_s = seg_decode(bcd_q_r[3:0]);
      default: seg_s = SEG_BLANK;
    endcase
  end

  assign an_s = ~(8'd1 << dig_idx_r);
  assign dp_s = ~((dig_idx_r == 3'd0) && ovf_q_r);

  // Output registers keep an, seg and dp aligned on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_slot_display.sv
// Directed bench for slot_display: expected BCD values are queued when a
// score is driven and popped when the conversion should have committed.
module tb_slot_display;
  import slot_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  resultMSB, result2, resultLSB;
  logic [31:0] score;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  slot_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .resultMSB (resultMSB),
    .result2   (result2),
    .resultLSB (resultLSB),
    .score     (score),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_bcd(input logic [31:0] s);
    int v;
    v = (s > 32'd9999) ? 9999 : int'(s);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [7:0] target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 100);
    if (an !== target) chk("an_timeout", an, target);
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    chk(tag, dut.bcd_q_r, e);
  endtask

  initial begin
    logic [31:0] bvals[3];
    bvals[0] = 32'd9999; bvals[1] = 32'd10000; bvals[2] = 32'hFFFFFFFF;

    reset = 1'b1; resultMSB = 4'd0; result2 = 4'd0; resultLSB = 4'd0; score = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
    end
    chk("rst_bcd", dut.bcd_q_r, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d0_an", an, 8'hFE);
      chk("d0_seg", seg, 7'h40);
    end
    @(negedge clk);
    chk("d1_an", an, 8'hFD);
    chk("d1_seg", seg, 7'h7F);

    // Reel decode, including an out-of-range digit.
    resultMSB = 4'd7; result2 = 4'd7; resultLSB = 4'd12;
    wait_an(8'h7F); chk("reel_msb", seg, 7'h78);
    wait_an(8'hBF); chk("reel_2", seg, 7'h78);
    wait_an(8'hDF); chk("reel_lsb", seg, 7'h3F);
    wait_an(8'hEF); chk("gap", seg, 7'h7F);

    // Score latency: committed exactly 16 cycles after the change.
    score = 32'd305; exp_q.push_back(model_bcd(score));
    repeat (15) @(negedge clk);
    chk("lat_early", dut.bcd_q_r, 16'h0000);
    @(negedge clk);
    pop_chk("lat_305");
    wait_an(8'hF7); chk("s305_d3", seg, 7'h7F); chk("s305_dp3", dp, 1'b1);
    wait_an(8'hFB); chk("s305_d2", seg, 7'h30);
    wait_an(8'hFD); chk("s305_d1", seg, 7'h40);
    wait_an(8'hFE); chk("s305_d0", seg, 7'h12); chk("s305_dp0", dp, 1'b1);

    // Saturation.
    score = 32'd123456; exp_q.push_back(model_bcd(score));
    repeat (16) @(negedge clk);
    pop_chk("sat_bcd");
    chk("sat_ovf", dut.ovf_q_r, 1'b1);
    wait_an(8'hF7); chk("sat_d3", seg, 7'h10); chk("sat_dp3", dp, 1'b1);
    wait_an(8'hFB); chk("sat_d2", seg, 7'h10);
    wait_an(8'hFD); chk("sat_d1", seg, 7'h10);
    wait_an(8'hFE); chk("sat_d0", seg, 7'h10); chk("sat_dp0", dp, 1'b0);

    // Saturation edges: 9999, 10000, all-ones.
    for (int i = 0; i < 3; i++) begin
      score = bvals[i]; exp_q.push_back(model_bcd(score));
      repeat (16) @(negedge clk);
      pop_chk("edge_bcd");
      chk("edge_ovf", dut.ovf_q_r, (bvals[i] > 32'd9999));
      wait_an(8'hFE);
      chk("edge_d0", seg, 7'h10);
      chk("edge_dp", dp, !(bvals[i] > 32'd9999));
    end

    // Score changes mid-conversion.
    score = 32'd42; exp_q.push_back(model_bcd(score));
    repeat (5) @(negedge clk);
    score = 32'd1000; exp_q.push_back(model_bcd(score));
    repeat (11) @(negedge clk);
    pop_chk("mid_first");
    repeat (15) @(negedge clk);
    chk("mid_hold", dut.bcd_q_r, 16'h0042);
    @(negedge clk);
    pop_chk("mid_second");
    wait_an(8'hF7); chk("mid_d3", seg, 7'h79);

    // Reset during conversion aborts it; restart on the first cycle after.
    score = 32'd9876;
    repeat (5) @(negedge clk);
    chk("pre_rst_state", dut.state_r, CONV);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_bcd", dut.bcd_q_r, 16'h0000);
    chk("abort_state", dut.state_r, IDLE);
    chk("abort_an", an, 8'hFF);
    reset = 1'b0; exp_q.push_back(model_bcd(score));
    @(negedge clk);
    chk("restart_state", dut.state_r, CONV);
    chk("restart_last", dut.last_score_r, 32'd9876);
    repeat (15) @(negedge clk);
    pop_chk("restart_bcd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
